ec1_datapath: RTL and testbench
===============================

Name: ec1_datapath

Overview:
- Datapath of the EC-1 accumulator processor; sits directly downstream of the control unit (CU / ControlUnit).
- Consumes the control word IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel.
- Produces the status that feeds back to the control unit: IR opcode, Aeq0, Apos.
- Holds PC, IR, accumulator A, unified program/data RAM, and the add/subtract unit.

Parameters:
- DATA_W, 8, width of A, memory words and IR; opcode is IR[DATA_W-1:DATA_W-3].
- ADDR_W, 5, PC/address width; memory depth is 2^ADDR_W words; operand address is IR[ADDR_W-1:0]; requires ADDR_W <= DATA_W-3.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- IRload  in  1  load IR from memory
- JMPmux  in  1  PC source: 0 = PC+1, 1 = IR address field
- PCload  in  1  load PC
- Meminst  in  1  memory address source: 0 = PC, 1 = IR address field
- MemWr  in  1  write A to memory
- Aload  in  1  load A
- Sub  in  1  adder mode: 0 = A+M, 1 = A-M
- Halt  in  1  halt request from control unit
- Asel  in  2  A source: 00 adder, 01 Input, 10 memory, 11 zero
- Input  in  DATA_W  external input switches
- ProgWe  in  1  program-load write strobe
- ProgAddr  in  ADDR_W  program-load address
- ProgData  in  DATA_W  program-load data
- IR  out  3  opcode, IR register bits [DATA_W-1:DATA_W-3]
- Aeq0  out  1  A == 0
- Apos  out  1  ~A[DATA_W-1] (A non-negative, two's complement)
- Output  out  DATA_W  A, driven continuously
- Halted  out  1  sticky halt indicator
- Ovf  out  1  signed-overflow flag (see Optional Feature)

Behaviour:
- Reset, synchronous at the rising edge:
  - PC=0, IR reg=0, A=0, Halted=0, Ovf=0.
  - Consequently IR=000, Aeq0=1, Apos=1, Output=0.
  - Memory contents are not cleared.
  - Reset overrides every load asserted in the same cycle, including a mid-instruction reset.
- Memory address mux: addr = Meminst ? IR[ADDR_W-1:0] : PC. M = mem[addr], read asynchronously (combinational).
- Memory write, synchronous:
  - If ProgWe: mem[ProgAddr] <= ProgData.
  - Else if MemWr and not Halted: mem[addr] <= A (value of A before the edge).
  - ProgWe wins on a simultaneous MemWr. ProgWe is honoured even while Reset or Halted.
- IR: on IRload, IR reg <= M (full DATA_W word).
- PC: on PCload, PC <= JMPmux ? IR[ADDR_W-1:0] : PC+1.
  - Increment wraps modulo 2^ADDR_W (31 -> 0 at default).
  - A jump uses the IR value before the edge.
- IRload and PCload in the same cycle (fetch): IR gets mem[old PC] and PC becomes old PC+1, both at the same edge.
- Adder: S = Sub ? A - M : A + M, modulo 2^DATA_W; carry/borrow discarded.
- A: on Aload, A <= per Asel: 00 = S, 01 = Input, 10 = M, 11 = 0.
- MemWr and Aload in the same cycle: memory stores the old A.
- Aeq0 and Apos are combinational from the A register, valid 0 cycles after the edge that updates A.
- Halt:
  - Halt=1 at an edge sets Halted=1 (sticky until Reset).
  - From the following edge, IRload, PCload, Aload and MemWr are ignored; registers hold.
  - Loads asserted in the same edge as Halt still take effect.
- Control inputs are sampled only at rising edges. No internal state machine beyond the Halted flag; sequencing belongs to the control unit.

Optional Feature:
- Macro: EC1_DP_OVERFLOW_EN.
- Defined:
  - Ovf is a register updated on every Aload with Asel=00.
  - Ovf <= signed overflow of the add/sub: operands of equal sign (A, M for add; A, ~M for sub) and result sign differs.
  - Aload with any other Asel clears Ovf. Ovf holds otherwise. Reset clears it.
- Undefined: Ovf tied to 0; no overflow logic synthesized.

Test Plan:
- Reset with Aload=1, PCload=1, Input=8'h55 -> after the edge PC=0, A=0, IR=000, Aeq0=1, Apos=1, Halted=0.
- ProgWe writes mem[0]=8'h43 and mem[3]=8'h07; fetch (IRload=1, PCload=1, JMPmux=0, Meminst=0) -> IR reg=8'h43, IR=010, PC=1. Then Meminst=1, Asel=10, Aload=1 -> A=8'h07, Aeq0=0, Apos=1.
- A=8'h07, mem[3]=8'h09, Sub=1, Asel=00, Aload=1 -> A=8'hFE, Apos=0, Aeq0=0. Repeat with Sub=0 and mem[3]=8'h02 -> A=8'h00, Aeq0=1.
- PC=31, PCload=1, JMPmux=0 -> PC=0 (wrap). IR reg=8'hB4, JMPmux=1, PCload=1 -> PC=5'h14.
- A=8'h3C, Meminst=1, IR addr=5, MemWr=1 with Aload=1, Asel=01, Input=8'h11 -> mem[5]=8'h3C, A=8'h11. Same cycle with ProgWe to address 5, data 8'hAA -> mem[5]=8'hAA.
- Halt=1 for one edge, then PCload/Aload/MemWr pulsed -> Halted=1 and PC/A/memory unchanged; Reset -> Halted=0. With EC1_DP_OVERFLOW_EN, A=8'h7F + M=8'h01 -> A=8'h80, Ovf=1.

Source files
------------

// File: rtl/ec1_datapath_if.sv
// EC-1 datapath bus: control word from the control unit, program-load port,
// external input switches, and the status/output signals returned by the datapath.
// master = control unit / environment side, slave = datapath side.
interface ec1_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    // Control word
    logic              IRload;
    logic              JMPmux;
    logic              PCload;
    logic              Meminst;
    logic              MemWr;
    logic              Aload;
    logic              Sub;
    logic              Halt;
    logic [1:0]        Asel;

    // External input switches
    logic [DATA_W-1:0] Input;

    // Program loader
    logic              ProgWe;
    logic [ADDR_W-1:0] ProgAddr;
    logic [DATA_W-1:0] ProgData;

    // Status back to the control unit and external outputs
    logic [2:0]        IR;
    logic              Aeq0;
    logic              Apos;
    logic [DATA_W-1:0] Output;
    logic              Halted;
    logic              Ovf;

    modport master (
        output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel,
        output Input, ProgWe, ProgAddr, ProgData,
        input  IR, Aeq0, Apos, Output, Halted, Ovf
    );

    modport slave (
        input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel,
        input  Input, ProgWe, ProgAddr, ProgData,
        output IR, Aeq0, Apos, Output, Halted, Ovf
    );
endinterface

// File: rtl/ec1_datapath.sv
// EC-1 accumulator processor datapath: PC, IR, accumulator A, unified
// program/data RAM and add/subtract unit, driven by the control unit's word.
// Optional macro EC1_DP_OVERFLOW_EN adds a registered signed-overflow flag;
// without it Ovf is tied low.
module ec1_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ec1_datapath_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ASEL_SUM  = 2'b00,
        ASEL_IN   = 2'b01,
        ASEL_MEM  = 2'b10,
        ASEL_ZERO = 2'b11
    } a_sel_e;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic              r_halted;

    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_m;
    logic [DATA_W-1:0] w_sum;
    logic              w_run;
    a_sel_e            w_asel;

    // Operand/instruction address: PC for fetches, IR address field for operands.
    assign w_addr = bus.Meminst ? r_ir[ADDR_W-1:0] : r_pc;
    assign w_m    = r_mem[w_addr];
    assign w_sum  = bus.Sub ? (r_a - w_m) : (r_a + w_m);
    assign w_run  = ~r_halted;
    assign w_asel = a_sel_e'(bus.Asel);

    // Memory write port: the program loader always wins over stores of A.
    // NOTE: the RAM has no reset branch on purpose; program contents must survive a
    // processor reset, and a reset on an array would also prevent RAM inference.
    always_ff @(posedge i_clk) begin
        if (bus.ProgWe) begin
            r_mem[bus.ProgAddr] <= bus.ProgData;
        end else if (bus.MemWr && w_run && !i_rst) begin
            r_mem[w_addr] <= r_a;
        end
    end

    // Architectural registers and the sticky halt flag; loads freeze once halted.
    // NOTE: non-blocking assignments make every right-hand side the pre-edge value,
    // which is what gives fetch (IR<=mem[PC], PC<=PC+1) and store-with-load their
    // same-edge semantics.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_halted <= 1'b0;
        end else begin
            if (bus.Halt) begin
                r_halted <= 1'b1;
            end
            if (w_run) begin
                if (bus.IRload) begin
                    r_ir <= w_m;
                end
                if (bus.PCload) begin
                    r_pc <= bus.JMPmux ? r_ir[ADDR_W-1:0] : r_pc + 1'b1;
                end
                if (bus.Aload) begin
                    case (w_asel)
                        ASEL_SUM:  r_a <= w_sum;
                        ASEL_IN:   r_a <= bus.Input;
                        ASEL_MEM:  r_a <= w_m;
                        ASEL_ZERO: r_a <= '0;
                    endcase
                end
            end
        end
    end

`ifdef EC1_DP_OVERFLOW_EN
    logic r_ovf;
    logic w_m_sign;
    logic w_ovf;

    // For subtraction the adder effectively sees ~M, so compare against that sign.
    assign w_m_sign = bus.Sub ? ~w_m[DATA_W-1] : w_m[DATA_W-1];
    assign w_ovf    = (r_a[DATA_W-1] == w_m_sign) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);

    // Overflow flag tracks every A load: adder result sets it, other sources clear it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_run && bus.Aload) begin
            r_ovf <= (w_asel == ASEL_SUM) ? w_ovf : 1'b0;
        end
    end

    assign bus.Ovf = r_ovf;
`else
    assign bus.Ovf = 1'b0;
`endif

    assign bus.IR     = r_ir[DATA_W-1 -: 3];
    assign bus.Aeq0   = (r_a == '0);
    assign bus.Apos   = ~r_a[DATA_W-1];
    assign bus.Output = r_a;
    assign bus.Halted = r_halted;

endmodule

// File: tb/tb_ec1_datapath.sv
// Testbench for ec1_datapath: directed scenarios with hand-derived constants,
// then randomized control words checked against an arithmetic reference model.
module tb_ec1_datapath;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int MODV   = 256;
`ifdef EC1_DP_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ec1_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ec1_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, kept as plain integers.
    int m_mem [DEPTH];
    int m_pc, m_ir, m_a;
    bit m_halted, m_ovf;

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int addr, m, a_old, ir_old, sa, sm, res;
        addr   = bus.Meminst ? (m_ir % DEPTH) : m_pc;
        m      = m_mem[addr];
        a_old  = m_a;
        ir_old = m_ir;
        sa     = (a_old >= MODV / 2) ? a_old - MODV : a_old;
        sm     = (m >= MODV / 2) ? m - MODV : m;
        res    = bus.Sub ? sa - sm : sa + sm;
        if (bus.ProgWe) m_mem[int'(bus.ProgAddr)] = int'(bus.ProgData);
        else if (bus.MemWr && !m_halted && !rst) m_mem[addr] = a_old;
        if (rst) begin
            m_pc = 0; m_ir = 0; m_a = 0; m_halted = 0; m_ovf = 0;
            return;
        end
        if (!m_halted) begin
            if (bus.IRload) m_ir = m;
            if (bus.PCload) m_pc = bus.JMPmux ? (ir_old % DEPTH) : (m_pc + 1) % DEPTH;
            if (bus.Aload) begin
                case (bus.Asel)
                    2'b00: begin m_a = (res + 2 * MODV) % MODV; m_ovf = (res > 127) || (res < -128); end
                    2'b01: begin m_a = int'(bus.Input); m_ovf = 0; end
                    2'b10: begin m_a = m; m_ovf = 0; end
                    default: begin m_a = 0; m_ovf = 0; end
                endcase
            end
        end
        if (bus.Halt) m_halted = 1;
    endtask

    task automatic idle();
        bus.IRload = 0; bus.JMPmux = 0; bus.PCload = 0; bus.Meminst = 0;
        bus.MemWr = 0; bus.Aload = 0; bus.Sub = 0; bus.Halt = 0; bus.Asel = 2'b00;
        bus.Input = '0; bus.ProgWe = 0; bus.ProgAddr = '0; bus.ProgData = '0;
    endtask

    // One clock: update the model, take the edge, settle, return inputs to idle.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic prog(input logic [4:0] addr, input logic [7:0] data);
        bus.ProgWe = 1; bus.ProgAddr = addr; bus.ProgData = data;
        tick();
    endtask

    task automatic load_a_mem(input logic meminst);
        bus.Aload = 1; bus.Asel = 2'b10; bus.Meminst = meminst;
        tick();
    endtask

    task automatic load_a_input(input logic [7:0] val);
        bus.Aload = 1; bus.Asel = 2'b01; bus.Input = val;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1; bus.Aload = 1; bus.Asel = 2'b01; bus.PCload = 1; bus.Input = 8'h55;
        tick();
        rst = 0;
        n_checks++; if (bus.Output !== 8'h00) begin n_errors++; $display("FAIL reset_a got %h want 00", bus.Output); end
        n_checks++; if (bus.IR !== 3'b000) begin n_errors++; $display("FAIL reset_ir got %b want 000", bus.IR); end
        n_checks++; if (bus.Aeq0 !== 1'b1 || bus.Apos !== 1'b1) begin n_errors++; $display("FAIL reset_flags got eq0=%b pos=%b want 1 1", bus.Aeq0, bus.Apos); end
        n_checks++; if (bus.Halted !== 1'b0 || bus.Ovf !== 1'b0) begin n_errors++; $display("FAIL reset_halt_ovf got %b %b want 0 0", bus.Halted, bus.Ovf); end
    endtask

    // Fill the RAM; the first half is written while Reset is held.
    task automatic test_prog_load();
        rst = 1;
        for (int i = 0; i < DEPTH / 2; i++) prog(5'(i), 8'($urandom));
        rst = 0;
        for (int i = DEPTH / 2; i < DEPTH; i++) prog(5'(i), 8'($urandom));
        prog(5'd0, 8'h43);
        prog(5'd1, 8'h5A);
        prog(5'd3, 8'h07);
    endtask

    task automatic test_fetch_load();
        bus.IRload = 1; bus.PCload = 1; bus.JMPmux = 0; bus.Meminst = 0;
        tick();
        n_checks++; if (bus.IR !== 3'b010) begin n_errors++; $display("FAIL fetch_ir got %b want 010", bus.IR); end
        load_a_mem(1'b0);
        n_checks++; if (bus.Output !== 8'h5A) begin n_errors++; $display("FAIL fetch_pc_is_1 got %h want 5a", bus.Output); end
        load_a_mem(1'b1);
        n_checks++; if (bus.Output !== 8'h07 || bus.Aeq0 !== 1'b0 || bus.Apos !== 1'b1) begin n_errors++; $display("FAIL operand_load got %h eq0=%b pos=%b want 07 0 1", bus.Output, bus.Aeq0, bus.Apos); end
        n_checks++; if (bus.Ovf !== 1'b0) begin n_errors++; $display("FAIL operand_load_ovf got %b want 0", bus.Ovf); end
    endtask

    task automatic test_addsub();
        prog(5'd3, 8'h09);
        bus.Aload = 1; bus.Asel = 2'b00; bus.Sub = 1; bus.Meminst = 1;
        tick();
        n_checks++; if (bus.Output !== 8'hFE || bus.Apos !== 1'b0 || bus.Aeq0 !== 1'b0) begin n_errors++; $display("FAIL sub got %h pos=%b eq0=%b want fe 0 0", bus.Output, bus.Apos, bus.Aeq0); end
        n_checks++; if (bus.Ovf !== 1'b0) begin n_errors++; $display("FAIL sub_ovf got %b want 0", bus.Ovf); end
        prog(5'd3, 8'h02);
        bus.Aload = 1; bus.Asel = 2'b00; bus.Sub = 0; bus.Meminst = 1;
        tick();
        n_checks++; if (bus.Output !== 8'h00 || bus.Aeq0 !== 1'b1 || bus.Apos !== 1'b1) begin n_errors++; $display("FAIL add_zero got %h eq0=%b pos=%b want 00 1 1", bus.Output, bus.Aeq0, bus.Apos); end
    endtask

    task automatic test_pc_jump_wrap();
        prog(5'd3, 8'h1F);
        prog(5'd31, 8'hB4);
        prog(5'd20, 8'h2D);
        bus.IRload = 1; bus.Meminst = 1;
        tick();
        n_checks++; if (bus.IR !== 3'b000) begin n_errors++; $display("FAIL ir_1f got %b want 000", bus.IR); end
        bus.PCload = 1; bus.JMPmux = 1;
        tick();
        load_a_mem(1'b0);
        n_checks++; if (bus.Output !== 8'hB4 || bus.Apos !== 1'b0) begin n_errors++; $display("FAIL jump_to_31 got %h pos=%b want b4 0", bus.Output, bus.Apos); end
        bus.PCload = 1; bus.JMPmux = 0;
        tick();
        load_a_mem(1'b0);
        n_checks++; if (bus.Output !== 8'h43) begin n_errors++; $display("FAIL pc_wrap got %h want 43", bus.Output); end
        bus.IRload = 1; bus.Meminst = 1;
        tick();
        n_checks++; if (bus.IR !== 3'b101) begin n_errors++; $display("FAIL ir_b4 got %b want 101", bus.IR); end
        bus.PCload = 1; bus.JMPmux = 1;
        tick();
        load_a_mem(1'b0);
        n_checks++; if (bus.Output !== 8'h2D) begin n_errors++; $display("FAIL jump_to_14 got %h want 2d", bus.Output); end
    endtask

    task automatic test_store();
        prog(5'd20, 8'h25);
        bus.IRload = 1; bus.Meminst = 1;
        tick();
        load_a_input(8'h3C);
        bus.MemWr = 1; bus.Meminst = 1; bus.Aload = 1; bus.Asel = 2'b01; bus.Input = 8'h11;
        tick();
        n_checks++; if (bus.Output !== 8'h11) begin n_errors++; $display("FAIL store_new_a got %h want 11", bus.Output); end
        load_a_mem(1'b1);
        n_checks++; if (bus.Output !== 8'h3C) begin n_errors++; $display("FAIL store_old_a got %h want 3c", bus.Output); end
        bus.MemWr = 1; bus.Meminst = 1; bus.ProgWe = 1; bus.ProgAddr = 5'd5; bus.ProgData = 8'hAA;
        bus.Aload = 1; bus.Asel = 2'b01; bus.Input = 8'h11;
        tick();
        load_a_mem(1'b1);
        n_checks++; if (bus.Output !== 8'hAA) begin n_errors++; $display("FAIL progwe_priority got %h want aa", bus.Output); end
    endtask

    task automatic test_overflow();
        prog(5'd5, 8'h01);
        load_a_input(8'h7F);
        bus.Aload = 1; bus.Asel = 2'b00; bus.Sub = 0; bus.Meminst = 1;
        tick();
        n_checks++; if (bus.Output !== 8'h80 || bus.Ovf !== OVF_EN) begin n_errors++; $display("FAIL add_ovf got %h ovf=%b want 80 %b", bus.Output, bus.Ovf, OVF_EN); end
        bus.Aload = 1; bus.Asel = 2'b00; bus.Sub = 1; bus.Meminst = 1;
        tick();
        n_checks++; if (bus.Output !== 8'h7F || bus.Ovf !== OVF_EN) begin n_errors++; $display("FAIL sub_ovf got %h ovf=%b want 7f %b", bus.Output, bus.Ovf, OVF_EN); end
        load_a_input(8'h00);
        n_checks++; if (bus.Ovf !== 1'b0 || bus.Aeq0 !== 1'b1) begin n_errors++; $display("FAIL ovf_clear got ovf=%b eq0=%b want 0 1", bus.Ovf, bus.Aeq0); end
    endtask

    task automatic test_halt();
        load_a_input(8'h66);
        bus.Halt = 1; bus.Aload = 1; bus.Asel = 2'b01; bus.Input = 8'h77;
        tick();
        n_checks++; if (bus.Output !== 8'h77 || bus.Halted !== 1'b1) begin n_errors++; $display("FAIL halt_edge got %h halted=%b want 77 1", bus.Output, bus.Halted); end
        bus.PCload = 1; bus.Aload = 1; bus.Asel = 2'b01; bus.Input = 8'h12; bus.MemWr = 1; bus.Meminst = 1;
        tick();
        n_checks++; if (bus.Output !== 8'h77 || bus.Halted !== 1'b1) begin n_errors++; $display("FAIL halt_hold got %h halted=%b want 77 1", bus.Output, bus.Halted); end
        rst = 1;
        tick();
        rst = 0;
        n_checks++; if (bus.Halted !== 1'b0 || bus.Output !== 8'h00) begin n_errors++; $display("FAIL halt_reset got halted=%b a=%h want 0 00", bus.Halted, bus.Output); end
        for (int i = 0; i < 5; i++) begin
            bus.PCload = 1;
            tick();
        end
        load_a_mem(1'b0);
        n_checks++; if (bus.Output !== 8'h01) begin n_errors++; $display("FAIL halt_no_store got %h want 01", bus.Output); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 39) == 0);
            bus.IRload   = 1'($urandom_range(0, 1));
            bus.JMPmux   = 1'($urandom_range(0, 1));
            bus.PCload   = 1'($urandom_range(0, 1));
            bus.Meminst  = 1'($urandom_range(0, 1));
            bus.MemWr    = !rst && ($urandom_range(0, 3) == 0);
            bus.Aload    = 1'($urandom_range(0, 1));
            bus.Sub      = 1'($urandom_range(0, 1));
            bus.Halt     = ($urandom_range(0, 29) == 0);
            bus.Asel     = 2'($urandom_range(0, 3));
            bus.Input    = 8'($urandom);
            bus.ProgWe   = ($urandom_range(0, 7) == 0);
            bus.ProgAddr = 5'($urandom);
            bus.ProgData = 8'($urandom);
            tick();
            rst = 0;
            n_checks++;
            if (bus.Output !== 8'(m_a) || bus.IR !== 3'(m_ir / DEPTH) || bus.Aeq0 !== (m_a == 0) ||
                bus.Apos !== (m_a < MODV / 2) || bus.Halted !== m_halted || bus.Ovf !== (OVF_EN && m_ovf)) begin
                n_errors++;
                $display("FAIL random cycle %0d got a=%h ir=%b eq0=%b pos=%b halted=%b ovf=%b want a=%h ir=%b halted=%b ovf=%b",
                         i, bus.Output, bus.IR, bus.Aeq0, bus.Apos, bus.Halted, bus.Ovf,
                         8'(m_a), 3'(m_ir / DEPTH), m_halted, OVF_EN && m_ovf);
            end
        end
    endtask

    initial begin
        rst = 0;
        idle();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_pc = 0; m_ir = 0; m_a = 0; m_halted = 0; m_ovf = 0;
        #2;
        test_reset();
        test_prog_load();
        test_fetch_load();
        test_addsub();
        test_pc_jump_wrap();
        test_store();
        test_overflow();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
